// File: rtl/bp_fpga_host_pkg.sv
// bp_fpga_host_pkg: shared UART receive types and constants for the FPGA host
package bp_fpga_host_pkg;

    localparam int uart_default_clk_per_bit_gp = 10416;

    typedef enum logic [2:0] {
        e_idle,
        e_start,
        e_data,
        e_parity,
        e_stop,
        e_wait_high
    } uart_rx_state_e;

    function automatic int safe_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// uart_baud_counter: bit-period counter with mid-bit and full-bit sample strobes
module uart_baud_counter
    import bp_fpga_host_pkg::*;
#(
    parameter int clk_per_bit_p = uart_default_clk_per_bit_gp
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clear_i,
    output logic half_o,
    output logic full_o
);

    localparam int cnt_w_lp = safe_clog2(clk_per_bit_p);

    logic [cnt_w_lp-1:0] cnt_r;

    // free-running count, zeroed while idle and at every bit sample
    always_ff @(posedge clk_i)
        if (reset_i || clear_i) cnt_r <= '0;
        else cnt_r <= cnt_r + 1'b1;

    assign half_o = cnt_r == cnt_w_lp'(clk_per_bit_p / 2 - 1);
    assign full_o = cnt_r == cnt_w_lp'(clk_per_bit_p - 1);

endmodule

// File: rtl/uart_rx_framer.sv
// uart_rx_framer: UART frame receiver with parity/stop checks and a one-entry output register; define UART_RX_SYNC_EN to add a 2-flop rx synchronizer
module uart_rx_framer
    import bp_fpga_host_pkg::*;
#(
    parameter int uart_clk_per_bit_p = uart_default_clk_per_bit_gp,
    parameter int uart_data_bits_p   = 8,
    parameter int uart_parity_bit_p  = 0,
    parameter int uart_parity_odd_p  = 0,
    parameter int uart_stop_bits_p   = 1
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        rx_i,
    output logic [uart_data_bits_p-1:0] data_o,
    output logic                        v_o,
    input  logic                        yumi_i,
    output logic                        parity_error_o,
    output logic                        frame_error_o,
    output logic                        overrun_o
);

    localparam int bit_w_lp = safe_clog2(uart_data_bits_p);

    logic rx_s;

`ifdef UART_RX_SYNC_EN
    logic [1:0] sync_r;

    // two-flop synchronizer, reset to the idle-high line level
    always_ff @(posedge clk_i)
        if (reset_i) sync_r <= 2'b11;
        else sync_r <= {sync_r[0], rx_i};

    assign rx_s = sync_r[1];
`else
    assign rx_s = rx_i;
`endif

    uart_rx_state_e              state_r;
    logic [bit_w_lp-1:0]         bit_r;
    logic                        stop_r;
    logic                        par_r;
    logic [uart_data_bits_p-1:0] shift_r;
    logic [uart_data_bits_p-1:0] data_r;
    logic                        v_r;
    logic                        pe_r;
    logic                        fe_r;
    logic                        ovr_r;
    logic                        half;
    logic                        full;
    logic                        sample;
    logic                        par_bad;

    assign sample  = (state_r == e_start) ? half
                   : (state_r inside {e_data, e_parity, e_stop}) && full;
    assign par_bad = (uart_parity_bit_p != 0) && par_r;

    uart_baud_counter #(.clk_per_bit_p(uart_clk_per_bit_p)) baud (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clear_i ((state_r == e_idle) || sample),
        .half_o  (half),
        .full_o  (full)
    );

    // frame state machine; error pulses and the output word are all registered here
    always_ff @(posedge clk_i)
        if (reset_i) begin
            state_r <= e_idle;
            bit_r   <= '0;
            stop_r  <= 1'b0;
            par_r   <= 1'b0;
            shift_r <= '0;
            data_r  <= '0;
            v_r     <= 1'b0;
            pe_r    <= 1'b0;
            fe_r    <= 1'b0;
            ovr_r   <= 1'b0;
        end else begin
            pe_r <= 1'b0;
            fe_r <= 1'b0;
            if (yumi_i) v_r <= 1'b0;
            case (state_r)
                e_idle: if (!rx_s) state_r <= e_start;
                e_start:
                    if (half) begin
                        state_r <= rx_s ? e_idle : e_data;
                        bit_r   <= '0;
                        stop_r  <= 1'b0;
                        par_r   <= 1'b0;
                    end
                e_data:
                    if (full) begin
                        shift_r <= {rx_s, shift_r[uart_data_bits_p-1:1]};
                        par_r   <= par_r ^ rx_s;
                        bit_r   <= bit_r + 1'b1;
                        if (bit_r == bit_w_lp'(uart_data_bits_p - 1))
                            state_r <= (uart_parity_bit_p != 0) ? e_parity : e_stop;
                    end
                e_parity:
                    if (full) begin
                        par_r   <= par_r ^ rx_s ^ (uart_parity_odd_p != 0);
                        state_r <= e_stop;
                    end
                e_stop:
                    if (full) begin
                        if (!rx_s) begin
                            fe_r    <= 1'b1;
                            state_r <= e_wait_high;
                        end else if (stop_r == 1'(uart_stop_bits_p - 1)) begin
                            state_r <= e_idle;
                            if (par_bad) pe_r <= 1'b1;
                            else if (v_r && !yumi_i) ovr_r <= 1'b1;
                            else begin
                                data_r <= shift_r;
                                v_r    <= 1'b1;
                            end
                        end else stop_r <= 1'b1;
                    end
                e_wait_high: if (rx_s) state_r <= e_idle;
                default: state_r <= e_idle;
            endcase
        end

    assign data_o         = data_r;
    assign v_o            = v_r;
    assign parity_error_o = pe_r;
    assign frame_error_o  = fe_r;
    assign overrun_o      = ovr_r;

endmodule

// File: tb/tb_uart_rx_framer.sv
// tb_uart_rx_framer: two framers (8N1 and 8E1) checked every cycle against a frame-level event model
module tb_uart_rx_framer;

    localparam int P = 16;
`ifdef UART_RX_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    typedef struct {
        int         at;
        int         inst;
        int         kind;
        logic [7:0] d;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] rx = 2'b11;
    logic [1:0] yumi = 2'b00;
    logic [1:0] v, pe, fe, ovr;
    logic [7:0] dat [2];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_seen = 0;
    logic started = 1'b0;

    ev_t  evq [$];
    logic mv [2];
    logic [7:0] md [2];
    logic movr [2];
    logic mpe [2];
    logic mfe [2];
    logic held [2];

    int   ymode [2] = '{0, 0};
    int   yprob [2] = '{100, 100};
    logic pv [2] = '{1'b0, 1'b0};
    int   vrise_cnt [2] = '{0, 0};
    int   vrise_cyc [2] = '{0, 0};
    logic [7:0] vrise_dat [2];
    int   pe_cnt [2] = '{0, 0};
    int   fe_cnt [2] = '{0, 0};

    always #5 clk = ~clk;

    uart_rx_framer #(.uart_clk_per_bit_p(P), .uart_data_bits_p(8), .uart_parity_bit_p(0),
                     .uart_parity_odd_p(0), .uart_stop_bits_p(1)) dut0 (
        .clk_i(clk), .reset_i(reset), .rx_i(rx[0]), .data_o(dat[0]), .v_o(v[0]),
        .yumi_i(yumi[0]), .parity_error_o(pe[0]), .frame_error_o(fe[0]), .overrun_o(ovr[0]));

    uart_rx_framer #(.uart_clk_per_bit_p(P), .uart_data_bits_p(8), .uart_parity_bit_p(1),
                     .uart_parity_odd_p(0), .uart_stop_bits_p(1)) dut1 (
        .clk_i(clk), .reset_i(reset), .rx_i(rx[1]), .data_o(dat[1]), .v_o(v[1]),
        .yumi_i(yumi[1]), .parity_error_o(pe[1]), .frame_error_o(fe[1]), .overrun_o(ovr[1]));

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d cycle %0d got %0h expected %0h", nm, i, cyc, act, exp);
        end
    endtask

    // model: frame outcomes land on their scheduled edge, then the one-entry holding register rules apply
    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            started = 1'b1;
            evq.delete();
            for (int i = 0; i < 2; i++) begin
                mv[i] = 1'b0; md[i] = '0; movr[i] = 1'b0; mpe[i] = 1'b0; mfe[i] = 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                held[i] = mv[i] && !yumi[i];
                mv[i]   = held[i];
                mpe[i]  = 1'b0;
                mfe[i]  = 1'b0;
            end
            for (int k = evq.size() - 1; k >= 0; k--)
                if (evq[k].at == cyc) begin
                    ev_t e;
                    e = evq[k];
                    evq.delete(k);
                    if (e.kind == 1) mpe[e.inst] = 1'b1;
                    else if (e.kind == 2) mfe[e.inst] = 1'b1;
                    else if (held[e.inst]) movr[e.inst] = 1'b1;
                    else begin
                        md[e.inst] = e.d;
                        mv[e.inst] = 1'b1;
                    end
                end
        end
    end

    // per-cycle comparison plus pulse/rise bookkeeping for the directed literal checks
    always @(negedge clk)
        if (started)
            for (int i = 0; i < 2; i++) begin
                chk("v_o", i, v[i], mv[i]);
                chk("data_o", i, dat[i], md[i]);
                chk("parity_error_o", i, pe[i], mpe[i]);
                chk("frame_error_o", i, fe[i], mfe[i]);
                chk("overrun_o", i, ovr[i], movr[i]);
                if (v[i] && !pv[i]) begin
                    vrise_cnt[i]++;
                    vrise_cyc[i] = cyc;
                    vrise_dat[i] = dat[i];
                end
                pv[i] = v[i];
                pe_cnt[i] += int'(pe[i]);
                fe_cnt[i] += int'(fe[i]);
            end

    // consumer: always-high, never, or a random take while a word is held
    initial
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++)
                yumi[i] = (ymode[i] == 1) ||
                          (ymode[i] == 2 && mv[i] && ($urandom_range(0, 99) < yprob[i]));
        end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // one frame on line i; instance 1 carries an even parity bit, optionally inverted
    task automatic send(input int i, input logic [7:0] d, input logic pflip, input logic stopv, input int hold);
        ev_t e;
        int  nb;
        nb     = 8 + ((i == 1) ? 1 : 0);
        e.inst = i;
        e.d    = d;
        e.at   = cyc + 1 + LAT + P / 2 + P * (nb + 1);
        e.kind = !stopv ? 2 : (pflip && i == 1) ? 1 : 0;
        evq.push_back(e);
        last_seen = cyc + 1;
        rx[i] = 1'b0;
        tick(P);
        for (int b = 0; b < 8; b++) begin
            rx[i] = d[b];
            tick(P);
        end
        if (i == 1) begin
            rx[i] = ^d ^ pflip;
            tick(P);
        end
        rx[i] = stopv;
        tick(P);
        if (!stopv) begin
            tick(hold);
            rx[i] = 1'b1;
            tick(2);
        end
    endtask

    task automatic glitch(input int i, input int g);
        rx[i] = 1'b0;
        tick(g);
        rx[i] = 1'b1;
        tick(P);
    endtask

    task automatic rnd_frame(input int i);
        int r;
        logic [7:0] d;
        r        = $urandom_range(0, 99);
        d        = 8'($urandom);
        yprob[i] = $urandom_range(20, 100);
        if (r < 10) glitch(i, $urandom_range(1, P / 2));
        else send(i, d, (i == 1 && r < 35) ? 1'b1 : 1'b0, (r >= 85) ? 1'b0 : 1'b1, $urandom_range(0, 30));
        tick($urandom_range(0, 5));
    endtask

    initial begin
        int b0, b1, b2;
        tick(3);
        reset = 1'b0;
        tick(3);

        ymode[0] = 1;
        b0 = vrise_cnt[0];
        send(0, 8'h55, 1'b0, 1'b1, 0);
        tick(4);
        chk("t037_vcount", 0, vrise_cnt[0] - b0, 1);
        chk("t037_data", 0, vrise_dat[0], 8'h55);
        chk("t037_latency", 0, vrise_cyc[0] - last_seen, 152 + LAT);
        chk("t037_v_low", 0, v[0], 1'b0);
        ymode[0] = 0;

        ymode[1] = 0;
        b0 = pe_cnt[1];
        b1 = vrise_cnt[1];
        send(1, 8'hA3, 1'b1, 1'b1, 0);
        tick(4);
        chk("t038_pe_count", 1, pe_cnt[1] - b0, 1);
        chk("t038_no_v", 1, vrise_cnt[1] - b1, 0);
        send(1, 8'hA3, 1'b0, 1'b1, 0);
        tick(4);
        chk("t038_v", 1, v[1], 1'b1);
        chk("t038_data", 1, dat[1], 8'hA3);
        ymode[1] = 2;
        yprob[1] = 100;
        tick(3);
        chk("t038_taken", 1, v[1], 1'b0);

        b0 = vrise_cnt[0];
        b1 = pe_cnt[0];
        b2 = fe_cnt[0];
        glitch(0, 4);
        chk("t039_no_v", 0, vrise_cnt[0] - b0, 0);
        chk("t039_no_err", 0, (pe_cnt[0] - b1) + (fe_cnt[0] - b2), 0);

        send(0, 8'h12, 1'b0, 1'b1, 0);
        send(0, 8'h34, 1'b0, 1'b1, 0);
        tick(4);
        chk("t040_data", 0, dat[0], 8'h12);
        chk("t040_overrun", 0, ovr[0], 1'b1);
        ymode[0] = 2;
        yprob[0] = 100;
        tick(3);
        chk("t040_taken", 0, v[0], 1'b0);
        chk("t040_overrun_sticky", 0, ovr[0], 1'b1);

        b0 = fe_cnt[0];
        b1 = vrise_cnt[0];
        send(0, 8'h7E, 1'b0, 1'b0, 100);
        chk("t041_fe_count", 0, fe_cnt[0] - b0, 1);
        chk("t041_no_v", 0, vrise_cnt[0] - b1, 0);
        send(0, 8'h01, 1'b0, 1'b1, 0);
        tick(4);
        chk("t041_next_v", 0, vrise_cnt[0] - b1, 1);
        chk("t041_next_data", 0, vrise_dat[0], 8'h01);

        ymode[0] = 0;
        b0 = vrise_cnt[0];
        rx[0] = 1'b0;
        tick(P);
        rx[0] = 1'b1;
        tick(3 * P + P / 2);
        reset = 1'b1;
        tick(2);
        chk("t042_v", 0, v[0], 1'b0);
        chk("t042_data", 0, dat[0], 8'h00);
        chk("t042_overrun", 0, ovr[0], 1'b0);
        chk("t042_errs", 0, {pe[0], fe[0]}, 2'b00);
        reset = 1'b0;
        tick(12 * P);
        chk("t042_no_partial", 0, vrise_cnt[0] - b0, 0);

        ymode[0] = 2;
        ymode[1] = 2;
        for (int k = 0; k < 30; k++)
            fork
                rnd_frame(0);
                rnd_frame(1);
            join
        tick(2 * P);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
